// File: rtl/regs_wport_arbiter.sv
// regs_wport_arbiter
//   Arbitrates the single write port of the pMIPS 32 x n register file between
//   the core writeback (requester A) and the I/O / coefficient loader
//   (requester B). A has fixed priority. B is guaranteed a grant after
//   MAX_WAIT consecutive denials, through a one-cycle FORCE_B state.
//   Writes issue one cycle after the handshake. Read/write collision flags let
//   the core forward data around the synchronous-write register file.
//
//   Optional build macro: ZERO_WRITE_DROP_EN
//     When this macro is defined, handshakes that target %0 are accepted but
//     never written. The `dropped` output pulses in place of w for those
//     handshakes.
//
// Ports
//   clk, reset            clock (rising edge), asynchronous active-high reset
//   a_valid/a_addr/a_data requester A write request; a_ready = accepted
//   b_valid/b_addr/b_data requester B write request; b_ready = accepted
//   raddr1, raddr2        core read addresses (mirror regfile read ports)
//   w, waddr, wdata       registered register-file write port
//   fwd1, fwd2            raddrN matches the write issuing this cycle (never %0)
//   forced                issuing write came from a starvation-forced B grant
//   dropped               (ZERO_WRITE_DROP_EN only) suppressed %0 write pulse
module regs_wport_arbiter #(
  parameter int n        = 8,
  parameter int MAX_WAIT = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         a_valid,
  input  logic [4:0]   a_addr,
  input  logic [n-1:0] a_data,
  output logic         a_ready,
  input  logic         b_valid,
  input  logic [4:0]   b_addr,
  input  logic [n-1:0] b_data,
  output logic         b_ready,
  input  logic [4:0]   raddr1,
  input  logic [4:0]   raddr2,
  output logic         w,
  output logic [4:0]   waddr,
  output logic [n-1:0] wdata,
  output logic         fwd1,
  output logic         fwd2,
`ifdef ZERO_WRITE_DROP_EN
  output logic         dropped,
`endif
  output logic         forced
);

  localparam logic [3:0] WAIT_LAST = 4'(MAX_WAIT - 1);
  localparam logic [3:0] WAIT_SAT  = 4'(MAX_WAIT);

  typedef enum logic {PRIO_A = 1'b0, FORCE_B = 1'b1} state_t;

  state_t       state, state_nxt;
  logic [3:0]   wait_cnt, wait_cnt_nxt;
  logic         a_hs, b_hs, hs;
  logic [4:0]   sel_addr;
  logic [n-1:0] sel_data;
  logic         issue;

  // Stage p0: arbitration (combinational ready, handshake, next state)
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    a_ready      = 1'b1;
    b_ready      = !a_valid;
    if (state == FORCE_B) begin
      a_ready = 1'b0;
      b_ready = 1'b1;
    end

    a_hs = a_valid && a_ready;
    b_hs = b_valid && b_ready;

    case (state)
      PRIO_A:  if (a_valid && b_valid && wait_cnt == WAIT_LAST) state_nxt = FORCE_B;
      // Leave FORCE_B after one cycle whether B completed or withdrew.
      FORCE_B: state_nxt = PRIO_A;
      default: state_nxt = PRIO_A;
    endcase

    if (b_hs || !b_valid)
      wait_cnt_nxt = 4'd0;
    else if (state == PRIO_A && a_valid && wait_cnt != WAIT_SAT)
      wait_cnt_nxt = wait_cnt + 4'd1;
  end

  // Ready rules guarantee a_hs and b_hs are mutually exclusive.
  assign hs       = a_hs || b_hs;
  assign sel_addr = b_hs ? b_addr : a_addr;
  assign sel_data = b_hs ? b_data : a_data;

`ifdef ZERO_WRITE_DROP_EN
  assign issue = hs && (sel_addr != 5'd0);
`else
  assign issue = hs;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= PRIO_A;
      wait_cnt <= 4'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Stage p1: registered write port towards the register file
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w      <= 1'b0;
      forced <= 1'b0;
      waddr  <= 5'd0;
      wdata  <= '0;
    end else begin
      w      <= issue;
      forced <= issue && b_hs && (state == FORCE_B);
      if (issue) begin
        waddr <= sel_addr;
        wdata <= sel_data;
      end
    end
  end

`ifdef ZERO_WRITE_DROP_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) dropped <= 1'b0;
    else       dropped <= hs && !issue;
  end
`endif

  assign fwd1 = w && (waddr == raddr1) && (waddr != 5'd0);
  assign fwd2 = w && (waddr == raddr2) && (waddr != 5'd0);

endmodule

// File: doc/regs_wport_arbiter.md
Name: regs_wport_arbiter

Overview:
- Arbitrates the single write port of the pMIPS 32 x n register file (`%0` reads as zero) between two requesters.
  - Requester A: core writeback.
  - Requester B: I/O / coefficient loader for the affine-transform datapath.
- Uses fixed priority to A, with a starvation guard for B.
- Drives registered `w`/`waddr`/`wdata` to the register file.
- Flags read/write collisions so the core can forward data around the synchronous-write register file.

Parameters:
- n, 8, data width of the register file.
- MAX_WAIT, 4, max consecutive cycles B may be valid-but-denied before a forced B grant; legal range 1..15.

Ports:
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- a_valid  input  1  A write request
- a_addr  input  5  A destination register
- a_data  input  n  A write data
- a_ready  output  1  A accepted this cycle when a_valid&&a_ready
- b_valid  input  1  B write request
- b_addr  input  5  B destination register
- b_data  input  n  B write data
- b_ready  output  1  B accepted this cycle when b_valid&&b_ready
- raddr1  input  5  core read address port 1 (mirrors regfile Raddr1)
- raddr2  input  5  core read address port 2 (mirrors regfile Raddr2)
- w  output  1  register-file write enable
- waddr  output  5  register-file write address
- wdata  output  n  register-file write data
- fwd1  output  1  raddr1 collides with the write issuing this cycle
- fwd2  output  1  raddr2 collides with the write issuing this cycle
- forced  output  1  current B grant is a starvation-forced grant

Behaviour:
- Reset (async, immediate): w=0, waddr=0, wdata=0, forced=0, wait_cnt=0, FSM=PRIO_A.
  - a_ready and b_ready evaluate with FSM=PRIO_A during reset but are ignored.
  - Reset mid-transfer discards any registered write; w drops immediately.
- FSM states:
  - PRIO_A (normal operation):
    - a_ready=1.
    - b_ready = !a_valid.
  - FORCE_B:
    - a_ready=0.
    - b_ready=1.
- FSM transitions:
  - PRIO_A -> FORCE_B when b_valid && a_valid && wait_cnt==MAX_WAIT-1. The denial in that cycle is the MAX_WAIT-th.
  - FORCE_B -> PRIO_A when b_valid (the B handshake completes).
  - FORCE_B -> PRIO_A when !b_valid (B withdrew). No write is issued and wait_cnt is cleared.
- Ready rules:
  - Ready is combinational from FSM state and the other requester's valid only, never from its own valid.
  - At most one handshake per cycle.
- wait_cnt (4 bits):
  - Increments in PRIO_A while b_valid && a_valid.
  - Clears on a B handshake, or when b_valid=0.
  - Saturates at MAX_WAIT.
- Write issue latency: 1 cycle.
  - A handshake in cycle t gives w=1, waddr=addr, wdata=data in cycle t+1.
  - No handshake in cycle t gives w=0 in t+1; waddr/wdata hold their last value.
  - `forced` is registered alongside w: 1 when the issuing write came from a FORCE_B grant.
- Back-to-back: a new handshake every cycle is legal; w stays high continuously.
- Collision flags, combinational:
  - fwd1 = w && (waddr==raddr1) && (waddr!=0).
  - fwd2 is the same using raddr2.
  - Address 0 never flags a collision.
- Requesters must hold addr/data stable while valid and not ready. Behaviour otherwise is undefined and need not be checked.

Optional Feature:
- Macro: ZERO_WRITE_DROP_EN.
- Defined:
  - A handshake whose addr==0 is still accepted (ready unchanged, wait_cnt cleared for B).
  - No write is issued: w=0 in the following cycle; waddr/wdata not updated.
  - Exposes output `dropped` (1 bit, registered, reset 0), which pulses 1 for one cycle in place of the suppressed w.
- Undefined:
  - Writes to `%0` are issued like any other (w=1, waddr=0). The register file discards them.
  - No `dropped` port.

Test Plan:
- Reset then a_valid=1, a_addr=3, a_data=8'h11 for one cycle -> a_ready=1, b_ready=0. Next cycle w=1, waddr=3, wdata=8'h11; cycle after, w=0.
- a_valid and b_valid both held high, MAX_WAIT=4:
  - A accepted for 4 consecutive cycles.
  - 5th cycle a_ready=0, b_ready=1.
  - B write issued next cycle with forced=1.
  - A resumes the following cycle.
- b_valid alone, b_addr=5, b_data=8'hAF -> b_ready=1, one-cycle latency write, forced=0, wait_cnt stays 0.
- Write to reg 2 issuing while raddr1=2, raddr2=1 -> fwd1=1, fwd2=0. Write to reg 0 with raddr1=raddr2=0 -> fwd1=fwd2=0.
- Assert reset asynchronously mid-cycle while w=1 and FSM=FORCE_B -> w=0 and forced=0 immediately. After release, b_ready follows PRIO_A rules with wait_cnt=0.
- a_valid, a_addr=0, a_data=8'hFF:
  - With ZERO_WRITE_DROP_EN: next cycle w=0, dropped=1.
  - Without: w=1, waddr=0, wdata=8'hFF.
